// File: rtl/vga_capture_pkg.sv
// Shared constants and types for the VGA capture block.
// Defaults describe 640x480@60 sampled by a 100 MHz clock (4 clk per VGA
// pixel) and a 128x96 downsampled capture image.
package vga_capture_pkg;

  localparam int unsigned LINE_CLK    = 3200;  // nominal clk per line
  localparam int unsigned LINE_TOL    = 4;     // +/- clk accepted per line
  localparam int unsigned H_START     = 576;   // first active h_cnt
  localparam int unsigned H_END       = 3135;  // last active h_cnt
  localparam int unsigned FRAME_LINES = 521;
  localparam int unsigned V_START     = 31;    // first active line
  localparam int unsigned V_END       = 510;   // last active line
  localparam int unsigned H_DIV       = 20;    // clk per output column
  localparam int unsigned H_PHASE     = 10;    // sample point inside a column
  localparam int unsigned V_DIV       = 5;     // lines per output row
  localparam int unsigned V_PHASE     = 2;     // sample line inside a row
  localparam int unsigned OUT_COLS    = 128;
  localparam int unsigned OUT_ROWS    = 96;

  localparam int unsigned H_CNT_W    = 12;
  localparam int unsigned LINE_CNT_W = 10;
  localparam int unsigned ADDR_W     = 14;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    VERIFY  = 2'd1,
    CAPTURE = 2'd2
  } state_e;

endpackage

// File: rtl/vga_capture_sync_edge_detect.sv
// Two-flop synchronizer for an active-low sync input plus a falling-edge
// pulse derived from the synchronized value and its one-cycle delayed copy.
// Ports: clk, reset (sync, active-high), async_in (raw pin),
//        fall_pulse (one cycle, high while sync has just gone 1->0).
module sync_edge_detect
  import vga_capture_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic fall_pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Idle level of the sync lines is high, so reset to 1 to avoid a
  // spurious falling edge right after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign fall_pulse = prev_q & ~sync_q;

endmodule

// File: rtl/vga_capture.sv
// VGA frame grabber: validates incoming HSYNC/VSYNC timing, then writes a
// downsampled image (row*COLS+col addressing) to an external capture memory.
// Ports: clk, reset (sync, active-high); VGA_HSYNC/VGA_VSYNC (active-low,
//        asynchronous); VGA_RED/GREEN/BLUE pixel bits; wr_en/wr_addr/wr_data
//        memory write port; locked (capturing); frame_done (last address
//        written); sync_error (one-cycle timing violation pulse).
module vga_capture
  import vga_capture_pkg::*;
#(
  parameter int unsigned P_LINE_CLK    = LINE_CLK,
  parameter int unsigned P_LINE_TOL    = LINE_TOL,
  parameter int unsigned P_H_START     = H_START,
  parameter int unsigned P_H_END       = H_END,
  parameter int unsigned P_FRAME_LINES = FRAME_LINES,
  parameter int unsigned P_V_START     = V_START,
  parameter int unsigned P_V_END       = V_END,
  parameter int unsigned P_H_DIV       = H_DIV,
  parameter int unsigned P_H_PHASE     = H_PHASE,
  parameter int unsigned P_V_DIV       = V_DIV,
  parameter int unsigned P_V_PHASE     = V_PHASE,
  parameter int unsigned P_COLS        = OUT_COLS,
  parameter int unsigned P_ROWS        = OUT_ROWS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        VGA_HSYNC,
  input  logic        VGA_VSYNC,
  input  logic        VGA_RED,
  input  logic        VGA_GREEN,
  input  logic        VGA_BLUE,
  output logic        wr_en,
  output logic [13:0] wr_addr,
  output logic [2:0]  wr_data,
  output logic        locked,
  output logic        frame_done,
  output logic        sync_error
);

  // h_cnt at an HSYNC edge is (line length - 1).
  localparam logic [11:0] LEN_MIN   = 12'(P_LINE_CLK - P_LINE_TOL - 1);
  localparam logic [11:0] LEN_MAX   = 12'(P_LINE_CLK + P_LINE_TOL - 1);
  localparam logic [11:0] H_STA_C   = 12'(P_H_START);
  localparam logic [11:0] H_END_C   = 12'(P_H_END);
  localparam logic [11:0] H_PRE_SAT = 12'hFFE;
  localparam logic [9:0]  V_STA_C   = 10'(P_V_START);
  localparam logic [9:0]  V_END_C   = 10'(P_V_END);
  localparam logic [9:0]  LAST_LINE = 10'(P_FRAME_LINES - 1);
  localparam logic [4:0]  H_DIV_M1  = 5'(P_H_DIV - 1);
  localparam logic [4:0]  H_PH_C    = 5'(P_H_PHASE);
  localparam logic [2:0]  V_DIV_M1  = 3'(P_V_DIV - 1);
  localparam logic [2:0]  V_PH_C    = 3'(P_V_PHASE);
  localparam logic [13:0] COLS_C    = 14'(P_COLS);
  localparam logic [13:0] LAST_ADDR = 14'(P_COLS * P_ROWS - 1);

  logic hs_fall, vs_fall;

  sync_edge_detect u_hs_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (VGA_HSYNC),
    .fall_pulse (hs_fall)
  );

  sync_edge_detect u_vs_sync (
    .clk        (clk),
    .reset      (reset),
    .async_in   (VGA_VSYNC),
    .fall_pulse (vs_fall)
  );

  logic [2:0]  rgb_meta_q, rgb_meta_d, rgb_sync_q, rgb_sync_d;
  logic [11:0] h_cnt_q, h_cnt_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic [4:0]  h_sub_q, h_sub_d;
  logic [6:0]  col_q, col_d;
  logic [2:0]  v_sub_q, v_sub_d;
  logic [6:0]  row_q, row_d;
  state_e      state_q, state_d;
  logic        bad_q, bad_d;
  logic        armed_q, armed_d;
  logic        wr_en_q, wr_en_d;
  logic [13:0] wr_addr_q, wr_addr_d;
  logic [2:0]  wr_data_q, wr_data_d;
  logic        locked_q, locked_d;
  logic        frame_done_q, frame_done_d;
  logic        sync_error_q, sync_error_d;

  logic        in_h, in_v, line_bad, line_ovf, h_sat, err;
  logic [13:0] addr;

  always_comb begin
    rgb_meta_d = {VGA_RED, VGA_GREEN, VGA_BLUE};
    rgb_sync_d = rgb_meta_q;

    // Horizontal counter, saturating so a lost HSYNC stays visible.
    h_cnt_d = h_cnt_q;
    if (hs_fall)              h_cnt_d = '0;
    else if (h_cnt_q != '1)   h_cnt_d = h_cnt_q + 12'd1;
    h_sat = !hs_fall && (h_cnt_q == H_PRE_SAT);

    line_cnt_d = line_cnt_q;
    if (vs_fall)      line_cnt_d = '0;
    else if (hs_fall) line_cnt_d = line_cnt_q + 10'd1;

    in_h = (h_cnt_q >= H_STA_C) && (h_cnt_q <= H_END_C);
    in_v = (line_cnt_q >= V_STA_C) && (line_cnt_q <= V_END_C);

    // Running sub-counters replace (x-start)/div and (x-start)%div.
    h_sub_d = h_sub_q;
    col_d   = col_q;
    if (hs_fall) begin
      h_sub_d = '0;
      col_d   = '0;
    end else if (in_h) begin
      if (h_sub_q == H_DIV_M1) begin
        h_sub_d = '0;
        col_d   = col_q + 7'd1;
      end else begin
        h_sub_d = h_sub_q + 5'd1;
      end
    end

    // Rows advance as each active line finishes.
    v_sub_d = v_sub_q;
    row_d   = row_q;
    if (vs_fall) begin
      v_sub_d = '0;
      row_d   = '0;
    end else if (hs_fall && in_v) begin
      if (v_sub_q == V_DIV_M1) begin
        v_sub_d = '0;
        row_d   = row_q + 7'd1;
      end else begin
        v_sub_d = v_sub_q + 3'd1;
      end
    end

    line_bad = hs_fall && ((h_cnt_q < LEN_MIN) || (h_cnt_q > LEN_MAX));
    line_ovf = hs_fall && !vs_fall && (line_cnt_q == LAST_LINE);

    // armed_q is low when VERIFY was entered mid-frame; the partial frame
    // is discarded silently and the next full frame is the one verified.
    state_d = state_q;
    bad_d   = bad_q;
    armed_d = armed_q;
    err     = 1'b0;
    case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = VERIFY;
          bad_d   = 1'b0;
          armed_d = 1'b1;
        end
      end
      VERIFY: begin
        if (line_bad || line_ovf) bad_d = 1'b1;
        if (vs_fall) begin
          if (armed_q) begin
            if (!bad_q && !line_bad && (line_cnt_q == LAST_LINE)) state_d = CAPTURE;
            else                                                 err     = 1'b1;
          end
          armed_d = 1'b1;
          bad_d   = 1'b0;
        end
      end
      CAPTURE: begin
        if (line_bad || line_ovf || (vs_fall && (line_cnt_q != LAST_LINE))) begin
          err     = 1'b1;
          state_d = VERIFY;
          bad_d   = 1'b0;
          armed_d = vs_fall;
        end
      end
      default: state_d = SEARCH;
    endcase
    if (h_sat) begin
      err     = 1'b1;
      state_d = SEARCH;
    end

    addr = ({7'b0, row_q} * COLS_C) + {7'b0, col_q};

    wr_en_d = (state_q == CAPTURE) && in_h && in_v &&
              (h_sub_q == H_PH_C) && (v_sub_q == V_PH_C) && !err;
    wr_addr_d    = wr_en_d ? addr : wr_addr_q;
    wr_data_d    = wr_en_d ? rgb_sync_q : wr_data_q;
    frame_done_d = wr_en_d && (addr == LAST_ADDR);
    locked_d     = (state_d == CAPTURE);
    sync_error_d = err;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_meta_q   <= '1;
      rgb_sync_q   <= '1;
      h_cnt_q      <= '0;
      line_cnt_q   <= '0;
      h_sub_q      <= '0;
      col_q        <= '0;
      v_sub_q      <= '0;
      row_q        <= '0;
      state_q      <= SEARCH;
      bad_q        <= 1'b0;
      armed_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      sync_error_q <= 1'b0;
    end else begin
      rgb_meta_q   <= rgb_meta_d;
      rgb_sync_q   <= rgb_sync_d;
      h_cnt_q      <= h_cnt_d;
      line_cnt_q   <= line_cnt_d;
      h_sub_q      <= h_sub_d;
      col_q        <= col_d;
      v_sub_q      <= v_sub_d;
      row_q        <= row_d;
      state_q      <= state_d;
      bad_q        <= bad_d;
      armed_q      <= armed_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
      sync_error_q <= sync_error_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign locked     = locked_q;
  assign frame_done = frame_done_q;
  assign sync_error = sync_error_q;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture using proportionally scaled timing (64 clk lines,
// 18-line frames, 8x6 output image) so many frames fit in a short run.
module tb_vga_capture;

  localparam int LINE    = 64;
  localparam int TOL     = 2;
  localparam int H_START = 16;
  localparam int H_END   = 47;
  localparam int H_DIV   = 4;
  localparam int H_PHASE = 2;
  localparam int FRAME   = 18;
  localparam int V_START = 3;
  localparam int V_END   = 14;
  localparam int V_DIV   = 2;
  localparam int V_PHASE = 1;
  localparam int COLS    = 8;
  localparam int ROWS    = 6;
  localparam int LAST    = COLS * ROWS - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hs = 1'b1, vs = 1'b1, r = 1'b0, g = 1'b0, b = 1'b0;
  logic        wr_en, locked, frame_done, sync_error;
  logic [13:0] wr_addr;
  logic [2:0]  wr_data;

  typedef struct { int addr; int data; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_tests = 0, n_fail = 0;
  int wr_cnt = 0, fd_cnt = 0, err_cnt = 0;

  always #5 clk = ~clk;

  vga_capture #(
    .P_LINE_CLK(LINE), .P_LINE_TOL(TOL), .P_H_START(H_START), .P_H_END(H_END),
    .P_FRAME_LINES(FRAME), .P_V_START(V_START), .P_V_END(V_END),
    .P_H_DIV(H_DIV), .P_H_PHASE(H_PHASE), .P_V_DIV(V_DIV), .P_V_PHASE(V_PHASE),
    .P_COLS(COLS), .P_ROWS(ROWS)
  ) dut (
    .clk(clk), .reset(reset),
    .VGA_HSYNC(hs), .VGA_VSYNC(vs), .VGA_RED(r), .VGA_GREEN(g), .VGA_BLUE(b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .locked(locked), .frame_done(frame_done), .sync_error(sync_error)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // pat 0: solid red; pat 1: R,G,B,R bars each a quarter of the width
  function automatic logic [2:0] colour(input int pat, input int c);
    if (pat == 0) return 3'b100;
    case ((c / (COLS / 4)) % 3)
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (sync_error) err_cnt++;
    if (frame_done) begin
      fd_cnt++;
      check("frame_done_at_last_addr", int'(wr_en && (wr_addr == 14'(LAST))), 1);
    end
    if (wr_en) begin
      wr_cnt++;
      check("write_expected", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("wr_addr", int'(wr_addr), mon_e.addr);
        check("wr_data", int'(wr_data), mon_e.data);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"},      int'(wr_en), 0);
    check({tag, "_wr_addr"},    int'(wr_addr), 0);
    check({tag, "_wr_data"},    int'(wr_data), 0);
    check({tag, "_locked"},     int'(locked), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_sync_error"}, int'(sync_error), 0);
  endtask

  // One line: HSYNC low for 8 clk, VSYNC low on lines 0-1, pixels in the
  // active window. Expected writes are queued when cap is set.
  task automatic drive_line(input int line, input int len, input int pat,
                            input bit cap, input int rst_at);
    logic [2:0] px;
    if (cap && line >= V_START && line <= V_END && (line - V_START) % V_DIV == V_PHASE)
      for (int c = 0; c < COLS; c++)
        sb.push_back('{addr: ((line - V_START) / V_DIV) * COLS + c, data: int'(colour(pat, c))});
    for (int j = 0; j < len; j++) begin
      @(negedge clk);
      hs = (j < 8) ? 1'b0 : 1'b1;
      vs = (line < 2) ? 1'b0 : 1'b1;
      px = 3'b000;
      if (line >= V_START && line <= V_END && j >= H_START && j <= H_END)
        px = colour(pat, (j - H_START) / H_DIV);
      {r, g, b} = px;
      if (j == rst_at) reset = 1'b1;
      if (rst_at >= 0 && j == rst_at + 1) begin
        reset = 1'b0;
        check_reset_outputs("midframe_reset");
      end
    end
  endtask

  task automatic run_frame(input string tag, input int pat, input int long_line,
                           input int rst_line, input bit cap, input int exp_w,
                           input int exp_fd, input int exp_err,
                           input bit lk_start, input bit lk_end);
    bit cap_l;
    wr_cnt = 0; fd_cnt = 0; err_cnt = 0;
    for (int l = 0; l < FRAME; l++) begin
      cap_l = cap && (long_line < 0 || l <= long_line) && (rst_line < 0 || l < rst_line);
      drive_line(l, (l == long_line) ? LINE + 6 : LINE, pat, cap_l, (l == rst_line) ? 30 : -1);
      if (l == 0) check({tag, "_locked_start"}, int'(locked), int'(lk_start));
    end
    check({tag, "_locked_end"}, int'(locked), int'(lk_end));
    check({tag, "_writes"}, wr_cnt, exp_w);
    check({tag, "_frame_done"}, fd_cnt, exp_fd);
    check({tag, "_sync_error"}, err_cnt, exp_err);
    check({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (20) @(negedge clk);

    //        tag    pat long rst cap  w  fd err lk0 lk1
    run_frame("f1",  0,  -1,  -1, 0,   0, 0, 0,  0,  0);
    run_frame("f2",  0,  -1,  -1, 1,  48, 1, 0,  1,  1);
    run_frame("f3",  0,  -1,  -1, 1,  48, 1, 0,  1,  1);
    run_frame("f4",  1,  -1,  -1, 1,  48, 1, 0,  1,  1);
    run_frame("f5",  0,   8,  -1, 1,  24, 0, 1,  1,  0);
    run_frame("f6",  0,  -1,  -1, 0,   0, 0, 0,  0,  0);
    run_frame("f7",  0,  -1,  -1, 1,  48, 1, 0,  1,  1);

    // HSYNC missing: h_cnt saturates, one error pulse, drop to SEARCH
    wr_cnt = 0; fd_cnt = 0; err_cnt = 0;
    hs = 1'b1; vs = 1'b1; {r, g, b} = 3'b000;
    repeat (5000) @(negedge clk);
    check("hold_sync_error", err_cnt, 1);
    check("hold_writes", wr_cnt, 0);
    check("hold_locked", int'(locked), 0);

    run_frame("f8",  0,  -1,  -1, 0,   0, 0, 0,  0,  0);
    run_frame("f9",  0,  -1,  -1, 1,  48, 1, 0,  1,  1);
    run_frame("f10", 1,  -1,   7, 1,  16, 0, 0,  1,  0);
    run_frame("f11", 0,  -1,  -1, 0,   0, 0, 0,  0,  0);
    run_frame("f12", 1,  -1,  -1, 1,  48, 1, 0,  1,  1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
